key_debounce: RTL and testbench

//  Front end of the note keypad. Takes the 14 raw, asynchronous, bouncing key inputs from the pins.
//  Per key: 2-FF synchroniser, then a debounce counter qualified by a sample strobe.

---
 rtl/sass_pkg.sv | 8 +
 rtl/key_debounce_if.sv | 20 ++
 rtl/key_debounce_ch.sv | 82 ++++++++
 rtl/key_debounce.sv | 34 +++
 tb/tb_key_debounce.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/sass_pkg.sv
// Shared keypad types, used by the debouncer and the note priority decoder.
package sass_pkg;

    localparam int NUM_KEYS = 14;

    typedef logic [NUM_KEYS-1:0] key_vec_t;

endpackage

// File: rtl/key_debounce_if.sv
// Keypad front-end bus: raw keys and sample strobe in, clean levels and edge pulses out.
interface key_debounce_if;
    import sass_pkg::*;

    key_vec_t keys_i;
    logic     strobe_i;
    key_vec_t synced_o;
    key_vec_t press_o;
    key_vec_t release_o;

    modport master (
        output keys_i, strobe_i,
        input  synced_o, press_o, release_o
    );

    modport slave (
        input  keys_i, strobe_i,
        output synced_o, press_o, release_o
    );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, strobed debounce counter, stable level.
// Press/release pulse flops exist only when KEY_EDGE_PULSE_EN is defined.
module key_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    input  logic strobe_i,
    output logic synced_o,
    output logic press_o,
    output logic release_o
);
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        s1_d     = key_i;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        // A return to the accepted level collapses the count even between strobes.
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (strobe_i && (cnt_q == CNT_LAST)) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else if (strobe_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments; reset is synchronous.
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign synced_o = stable_q;

`ifdef KEY_EDGE_PULSE_EN
    logic press_q, press_d;
    logic release_q, release_d;

    always_comb begin
        press_d   = stable_d & ~stable_q;
        release_d = ~stable_d & stable_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;
`else
    assign press_o   = 1'b0;
    assign release_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Keypad front end: NUM_KEYS independent debounce channels fanned in/out of the bus.
// Optional press/release pulses: define KEY_EDGE_PULSE_EN.
module key_debounce
    import sass_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic           clk,
    input logic           rst,
    key_debounce_if.slave bus
);
    key_vec_t synced;
    key_vec_t press;
    key_vec_t rel;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .key_i    (bus.keys_i[k]),
            .strobe_i (bus.strobe_i),
            .synced_o (synced[k]),
            .press_o  (press[k]),
            .release_o(rel[k])
        );
    end

    assign bus.synced_o  = synced;
    assign bus.press_o   = press;
    assign bus.release_o = rel;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (DEBOUNCE_CYCLES=4): vector table plus strobe/reset sequences.
module tb_key_debounce;
    import sass_pkg::*;

`ifdef KEY_EDGE_PULSE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    typedef struct {
        string    name;
        logic     rst;
        key_vec_t keys;
        logic     strobe;
        key_vec_t exp_synced;
        key_vec_t exp_press;
        key_vec_t exp_release;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t tbl[$];

    key_debounce_if kb ();

    key_debounce #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(kb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input key_vec_t act, input key_vec_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string nm, input int n, input logic r, input key_vec_t k,
                       input logic s, input key_vec_t es, input key_vec_t ep, input key_vec_t er);
        vec_t v;
        v.name        = nm;
        v.rst         = r;
        v.keys        = k;
        v.strobe      = s;
        v.exp_synced  = es;
        v.exp_press   = EDGE ? ep : '0;
        v.exp_release = EDGE ? er : '0;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic check_all(input string nm, input key_vec_t es, input key_vec_t ep,
                             input key_vec_t er);
        check({nm, ".synced"}, kb.synced_o, es);
        check({nm, ".press"}, kb.press_o, EDGE ? ep : '0);
        check({nm, ".release"}, kb.release_o, EDGE ? er : '0);
    endtask

    // Four strobe groups of three idle cycles then one strobe; synced[0] rises on the last.
    task automatic strobe_groups(input string nm);
        for (int g = 1; g <= 4; g++) begin
            kb.strobe_i = 1'b0;
            for (int i = 0; i < 3; i++) step();
            kb.strobe_i = 1'b1;
            step();
            check($sformatf("%s.strobe%0d", nm, g), kb.synced_o, (g == 4) ? 14'h0001 : 14'h0000);
        end
        kb.strobe_i = 1'b0;
    endtask

    initial begin
        kb.keys_i   = '0;
        kb.strobe_i = 1'b1;

        // Reset with all keys held, then re-qualification and release.
        add("rst",        3, 1, 14'h3FFF, 1, 14'h0000, 14'h0000, 14'h0000);
        add("requal",     5, 0, 14'h3FFF, 1, 14'h0000, 14'h0000, 14'h0000);
        add("requal_e6",  1, 0, 14'h3FFF, 1, 14'h3FFF, 14'h3FFF, 14'h0000);
        add("requal_hold",1, 0, 14'h3FFF, 1, 14'h3FFF, 14'h0000, 14'h0000);
        add("rel_all",    5, 0, 14'h0000, 1, 14'h3FFF, 14'h0000, 14'h0000);
        add("rel_all_e6", 1, 0, 14'h0000, 1, 14'h0000, 14'h0000, 14'h3FFF);
        add("rel_all_h",  1, 0, 14'h0000, 1, 14'h0000, 14'h0000, 14'h0000);
        // Clean press and release of key 5.
        add("press5",     5, 0, 14'h0020, 1, 14'h0000, 14'h0000, 14'h0000);
        add("press5_e6",  1, 0, 14'h0020, 1, 14'h0020, 14'h0020, 14'h0000);
        add("press5_h",   1, 0, 14'h0020, 1, 14'h0020, 14'h0000, 14'h0000);
        add("rel5",       5, 0, 14'h0000, 1, 14'h0020, 14'h0000, 14'h0000);
        add("rel5_e6",    1, 0, 14'h0000, 1, 14'h0000, 14'h0000, 14'h0020);
        // Bounce on key 9: 3 high, 1 low, 2 high, low.
        add("bounce_a",   3, 0, 14'h0200, 1, 14'h0000, 14'h0000, 14'h0000);
        add("bounce_b",   1, 0, 14'h0000, 1, 14'h0000, 14'h0000, 14'h0000);
        add("bounce_c",   2, 0, 14'h0200, 1, 14'h0000, 14'h0000, 14'h0000);
        add("bounce_d",   4, 0, 14'h0000, 1, 14'h0000, 14'h0000, 14'h0000);
        // Simultaneous press of keys 0 and 13.
        add("simul",      5, 0, 14'h2001, 1, 14'h0000, 14'h0000, 14'h0000);
        add("simul_e6",   1, 0, 14'h2001, 1, 14'h2001, 14'h2001, 14'h0000);
        add("simul_h",    1, 0, 14'h2001, 1, 14'h2001, 14'h0000, 14'h0000);

        foreach (tbl[i]) begin
            rst         = tbl[i].rst;
            kb.keys_i   = tbl[i].keys;
            kb.strobe_i = tbl[i].strobe;
            step();
            check_all($sformatf("%s[%0d]", tbl[i].name, i),
                      tbl[i].exp_synced, tbl[i].exp_press, tbl[i].exp_release);
        end

        // Strobe gating: qualification advances only on strobed cycles.
        rst = 1'b1; kb.keys_i = '0; step(); rst = 1'b0;
        kb.keys_i = 14'h0001; kb.strobe_i = 1'b0;
        step(); step();
        for (int i = 0; i < 10; i++) step();
        check("strobe.frozen", kb.synced_o, 14'h0000);
        strobe_groups("gate");

        // Glitch between strobes restarts the count.
        rst = 1'b1; kb.keys_i = '0; step(); rst = 1'b0;
        kb.keys_i = 14'h0001; kb.strobe_i = 1'b0;
        step(); step();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 3; i++) step();
            kb.strobe_i = 1'b1; step(); kb.strobe_i = 1'b0;
        end
        kb.keys_i = 14'h0000; step();
        kb.keys_i = 14'h0001; step(); step(); step();
        check("glitch.still_low", kb.synced_o, 14'h0000);
        strobe_groups("glitch");

        // Release of key 3 interrupted by reset: level drops at once, no release pulse.
        rst = 1'b1; kb.keys_i = '0; kb.strobe_i = 1'b1; step(); rst = 1'b0;
        kb.keys_i = 14'h0008;
        for (int i = 0; i < 7; i++) step();
        check("rel3.stable", kb.synced_o, 14'h0008);
        kb.keys_i = 14'h0000;
        step(); step();
        check_all("rel3.counting", 14'h0008, 14'h0000, 14'h0000);
        rst = 1'b1; step();
        check_all("rel3.in_rst", 14'h0000, 14'h0000, 14'h0000);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_all($sformatf("rel3.after%0d", i), 14'h0000, 14'h0000, 14'h0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
